// File: rtl/qam_pkg.sv
// qam_pkg: baud codes, tick masks, Gray level codes and level helper shared by the QAM mapper
package qam_pkg;
    typedef enum logic [1:0] {
        BAUD_9600  = 2'b00,
        BAUD_19200 = 2'b01,
        BAUD_38400 = 2'b10,
        BAUD_76800 = 2'b11
    } baud_e;
    localparam logic [2:0] TICK_MASK_9600  = 3'b111;
    localparam logic [2:0] TICK_MASK_19200 = 3'b011;
    localparam logic [2:0] TICK_MASK_38400 = 3'b001;
    localparam logic [2:0] TICK_MASK_76800 = 3'b000;
    localparam logic [1:0] GRAY_N3 = 2'b00;
    localparam logic [1:0] GRAY_N1 = 2'b01;
    localparam logic [1:0] GRAY_P1 = 2'b11;
    localparam logic [1:0] GRAY_P3 = 2'b10;

    // tick fires when every phase-counter bit selected by the mask is set
    function automatic logic [2:0] tick_mask(input baud_e baud);
        return baud == BAUD_9600  ? TICK_MASK_9600  :
               baud == BAUD_19200 ? TICK_MASK_19200 :
               baud == BAUD_38400 ? TICK_MASK_38400 : TICK_MASK_76800;
    endfunction

    function automatic logic signed [31:0] gray2_level(input logic [1:0] code, input logic signed [31:0] amp);
        logic signed [31:0] amp3;
        amp3 = (amp <<< 1) + amp;
        return code == GRAY_N3 ? -amp3 :
               code == GRAY_N1 ? -amp  :
               code == GRAY_P1 ?  amp  : amp3;
    endfunction
endpackage

// File: rtl/qam_level_lut.sv
// qam_level_lut: 2-bit Gray code to signed 32-bit amplitude level
module qam_level_lut
    import qam_pkg::*;
#(
    parameter logic signed [31:0] AMP = 32'sd8192
) (
    input  logic        [1:0]  code,
    output logic signed [31:0] level
);
    assign level = gray2_level(code, AMP);
endmodule

// File: rtl/qam_symbol_mapper.sv
// qam_symbol_mapper: byte stream to held I/Q QAM levels, one symbol per baud tick of the sample clock
module qam_symbol_mapper
    import qam_pkg::*;
#(
    parameter int                 BPS = 4,
    parameter logic signed [31:0] AMP = 32'sd8192
) (
    input  logic               clk_filter_sample,
    input  logic               rst_n,
    input  logic        [1:0]  baud_rate,
    input  logic        [7:0]  data_in,
    input  logic               data_valid,
    output logic               data_ready,
    output logic signed [31:0] symb_i,
    output logic signed [31:0] symb_q,
    output logic               symb_valid,
    output logic               underrun
);
    localparam logic [3:0] BPS_W = 4'(BPS);

    logic        [2:0]     cnt_q, cnt_d, mask;
    logic        [3:0]     bits_left_q, bits_left_d;
    logic        [7:0]     sreg_q, sreg_d, src;
    logic signed [31:0]    symb_i_q, symb_i_d, symb_q_q, symb_q_d, lvl_i, lvl_q;
    logic                  symb_valid_q, symb_valid_d, underrun_q, underrun_d;
    logic                  tick, have_bits, emit;
    logic        [BPS-1:0] sym;

    assign mask       = tick_mask(baud_e'(baud_rate));
    assign tick       = (cnt_q & mask) == mask;
    assign have_bits  = bits_left_q != 4'd0;
    assign data_ready = !have_bits;
    // an empty shifter on a tick takes the incoming byte directly, so there is no bubble
    assign src        = have_bits ? sreg_q : data_in;
    assign sym        = src[7 -: BPS];
    assign emit       = have_bits || data_valid;

    if (BPS == 4) begin : g_qam16
        qam_level_lut #(.AMP(AMP)) u_lut_i (.code(sym[3:2]), .level(lvl_i));
        qam_level_lut #(.AMP(AMP)) u_lut_q (.code(sym[1:0]), .level(lvl_q));
    end else if (BPS == 2) begin : g_qam4
        assign lvl_i = sym[1] ? AMP : -AMP;
        assign lvl_q = sym[0] ? AMP : -AMP;
    end else begin : g_bad_bps
        $error("qam_symbol_mapper: BPS must be 2 or 4");
    end

    always_comb begin
        cnt_d        = cnt_q + 3'd1;
        sreg_d       = sreg_q;
        bits_left_d  = bits_left_q;
        symb_i_d     = symb_i_q;
        symb_q_d     = symb_q_q;
        symb_valid_d = tick;
        underrun_d   = tick && !emit;
        if (tick) begin
            symb_i_d = emit ? lvl_i : '0;
            symb_q_d = emit ? lvl_q : '0;
            if (emit) begin
                sreg_d      = src << BPS;
                bits_left_d = (have_bits ? bits_left_q : 4'd8) - BPS_W;
            end
        end else if (data_valid && !have_bits) begin
            sreg_d      = data_in;
            bits_left_d = 4'd8;
        end
    end

    always_ff @(posedge clk_filter_sample or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            sreg_q       <= '0;
            bits_left_q  <= '0;
            symb_i_q     <= '0;
            symb_q_q     <= '0;
            symb_valid_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sreg_q       <= sreg_d;
            bits_left_q  <= bits_left_d;
            symb_i_q     <= symb_i_d;
            symb_q_q     <= symb_q_d;
            symb_valid_q <= symb_valid_d;
            underrun_q   <= underrun_d;
        end
    end

    assign symb_i     = symb_i_q;
    assign symb_q     = symb_q_q;
    assign symb_valid = symb_valid_q;
    assign underrun   = underrun_q;
endmodule

// File: tb/tb_qam_symbol_mapper.sv
// tb_qam_symbol_mapper: directed checks of the QAM mapper for 16-QAM and 4-QAM builds
module tb_qam_symbol_mapper;
    localparam int A = 8192;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        baud_rate = 2'b00;
    logic [7:0]        data_in = 8'h00;
    logic              data_valid = 1'b0;
    logic              rdy4, vld4, und4, rdy2, vld2, und2;
    logic signed [31:0] i4, q4, i2, q2;
    logic [31:0]       cyc;
    int                vectors = 0;
    int                miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) cyc <= !rst_n ? 32'd0 : cyc + 32'd1;

    qam_symbol_mapper #(.BPS(4), .AMP(32'sd8192)) u4 (
        .clk_filter_sample(clk), .rst_n(rst_n), .baud_rate(baud_rate), .data_in(data_in),
        .data_valid(data_valid), .data_ready(rdy4), .symb_i(i4), .symb_q(q4),
        .symb_valid(vld4), .underrun(und4));

    qam_symbol_mapper #(.BPS(2), .AMP(32'sd8192)) u2 (
        .clk_filter_sample(clk), .rst_n(rst_n), .baud_rate(baud_rate), .data_in(data_in),
        .data_valid(data_valid), .data_ready(rdy2), .symb_i(i2), .symb_q(q2),
        .symb_valid(vld2), .underrun(und2));

    function automatic logic signed [31:0] lvl(input logic [1:0] g);
        return g == 2'b00 ? -3 * A : g == 2'b01 ? -A : g == 2'b11 ? A : 3 * A;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int n, last, pulses;
        logic found, acc, tick, ev, eu;
        logic signed [31:0] ei, eq;
        logic [3:0] s;
        logic [3:0] sq[$];
        logic signed [31:0] t3_i[4];
        logic signed [31:0] t3_q[4];
        t3_i = '{A, -A, -A, A};
        t3_q = '{-A, A, -A, A};

        // reset state
        #1;
        chk("rst_i", i4, 0);
        chk("rst_q", q4, 0);
        chk("rst_valid", 32'(vld4), 0);
        chk("rst_underrun", 32'(und4), 0);
        chk("rst_ready", 32'(rdy4), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: idle at 9600 baud gives an underrun pulse every 8 cycles
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("t1_valid", 32'(vld4), 32'(k % 8 == 0));
            if (k % 8 == 0) begin
                chk("t1_underrun", 32'(und4), 1);
                chk("t1_i", i4, 0);
                chk("t1_q", q4, 0);
            end
        end

        // 2: 76800 baud, 0xB4 then 0x6C back to back
        baud_rate = 2'b11; data_in = 8'hB4; data_valid = 1'b1;
        @(negedge clk);
        chk("t2_s1_i", i4, 3 * A); chk("t2_s1_q", q4, A);
        chk("t2_s1_valid", 32'(vld4), 1); chk("t2_s1_underrun", 32'(und4), 0);
        chk("t2_s1_ready", 32'(rdy4), 0);
        @(negedge clk);
        chk("t2_s2_i", i4, -A); chk("t2_s2_q", q4, -3 * A);
        chk("t2_s2_valid", 32'(vld4), 1); chk("t2_s2_underrun", 32'(und4), 0);
        chk("t2_s2_ready", 32'(rdy4), 1);
        data_in = 8'h6C;
        @(negedge clk);
        chk("t2_s3_i", i4, -A); chk("t2_s3_q", q4, 3 * A); chk("t2_s3_ready", 32'(rdy4), 0);
        data_valid = 1'b0;
        @(negedge clk);
        chk("t2_s4_i", i4, A); chk("t2_s4_q", q4, -3 * A); chk("t2_s4_underrun", 32'(und4), 0);
        @(negedge clk);
        chk("t2_idle_underrun", 32'(und4), 1); chk("t2_idle_i", i4, 0);
        repeat (2) @(negedge clk);

        // 3: 4-QAM at 38400 baud, byte 0x93
        baud_rate = 2'b10; data_in = 8'h93; data_valid = 1'b1;
        n = 0; last = 0; acc = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (vld2 && n < 4) begin
                chk("t3_i", i2, t3_i[n]);
                chk("t3_q", q2, t3_q[n]);
                chk("t3_underrun", 32'(und2), 0);
                if (n > 0) chk("t3_spacing", k - last, 2);
                last = k;
                n++;
            end
            if (acc) chk("t3_ready", 32'(rdy2), 32'(n == 4));
            if (data_valid && !rdy2) begin
                data_valid = 1'b0;
                acc = 1'b1;
            end
        end
        chk("t3_count", n, 4);

        // 4: switch 9600 -> 76800 after the first symbol of 0x6C
        baud_rate = 2'b00; data_in = 8'h6C; data_valid = 1'b1; found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (data_valid && !rdy4) data_valid = 1'b0;
            if (vld4) found = 1'b1;
        end
        chk("t4_found", 32'(found), 1);
        chk("t4_s1_i", i4, -A); chk("t4_s1_q", q4, 3 * A);
        chk("t4_cnt_a", 32'(u4.cnt_q), 32'(cyc[2:0]));
        baud_rate = 2'b11;
        @(negedge clk);
        chk("t4_s2_valid", 32'(vld4), 1); chk("t4_s2_underrun", 32'(und4), 0);
        chk("t4_s2_i", i4, A); chk("t4_s2_q", q4, -3 * A);
        chk("t4_cnt_b", 32'(u4.cnt_q), 32'(cyc[2:0]));
        @(negedge clk);
        chk("t4_after_underrun", 32'(und4), 1);
        repeat (4) @(negedge clk);

        // 5: asynchronous reset in the middle of byte 0xF0
        baud_rate = 2'b00; data_in = 8'hF0; data_valid = 1'b1; found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (data_valid && !rdy4) data_valid = 1'b0;
            if (vld4) found = 1'b1;
        end
        chk("t5_found", 32'(found), 1);
        chk("t5_s1_i", i4, A);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_i", i4, 0); chk("t5_rst_q", q4, 0);
        chk("t5_rst_valid", 32'(vld4), 0); chk("t5_rst_ready", 32'(rdy4), 1);
        chk("t5_rst_i2", i2, 0);
        data_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (vld4) begin
                pulses++;
                chk("t5_post_underrun", 32'(und4), 1);
                chk("t5_post_i", i4, 0);
                chk("t5_post_q", q4, 0);
            end
        end
        chk("t5_pulses", pulses, 2);

        // 6: 19200 baud with random valid gaps against a symbol queue
        baud_rate = 2'b01;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 64; k++) begin
            data_valid = ($urandom_range(0, 2) == 0);
            data_in = 8'($urandom);
            tick = (cyc[1:0] == 2'b11);
            chk("t6_ready", 32'(rdy4), 32'(sq.size() == 0));
            if (data_valid && sq.size() == 0) begin
                sq.push_back(data_in[7:4]);
                sq.push_back(data_in[3:0]);
            end
            ev = tick; eu = 1'b0; ei = 0; eq = 0;
            if (tick) begin
                if (sq.size() != 0) begin
                    s = sq.pop_front();
                    ei = lvl(s[3:2]);
                    eq = lvl(s[1:0]);
                end else eu = 1'b1;
            end
            @(negedge clk);
            chk("t6_valid", 32'(vld4), 32'(ev));
            if (ev) begin
                chk("t6_underrun", 32'(und4), 32'(eu));
                chk("t6_i", i4, ei);
                chk("t6_q", q4, eq);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
